// File: rtl/gray2bin_tracker.sv
// gray2bin_tracker: receive side of a Gray-coded position path.
// The block synchronises gray_in, decodes it to binary, and checks that each
// change is a single-bit step. It keeps a signed up/down position and reports
// each step through a one-entry valid/ready output register.
// Optional build macro GRAY2BIN_ERRCNT_EN adds an 8-bit saturating count of
// illegal transitions (err_cnt).
//
// Handshake: an entry transfers on an edge where out_valid && out_ready.
// out_valid stays high, with stable out_bin/out_dir/out_pos, until that edge.
// A new event may load on the same edge that the previous entry is consumed.
module gray2bin_tracker #(
  parameter int WIDTH       = 4,
  parameter int POS_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 en,
  input  logic                 clear_err,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 out_dir,
  output logic [POS_WIDTH-1:0] out_pos,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 err,
  output logic                 overflow,
`ifdef GRAY2BIN_ERRCNT_EN
  output logic [7:0]           err_cnt,
`endif
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     G_ONE = WIDTH'(1);
  localparam logic [POS_WIDTH-1:0] P_ONE = POS_WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     g_s, g_prev, g_diff, bin_s, bin_prev;
  logic                 active, one_hot, step_ok, step_bad, step_dir;
  logic                 consume, can_load;
  logic [POS_WIDTH-1:0] pos_q, pos_step;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Input synchroniser chain; it runs regardless of en and the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Step classification: a legal step has exactly one differing bit. Direction
  // is up only when the new value is exactly the old value + 1 (with wrap).
  always_comb begin
    g_diff   = g_s ^ g_prev;
    bin_s    = gray_to_bin(g_s);
    bin_prev = gray_to_bin(g_prev);
    active   = en && (state_q == S_TRACK);
    one_hot  = (g_diff != '0) && ((g_diff & (g_diff - G_ONE)) == '0);
    step_ok  = active && one_hot;
    step_bad = active && (g_diff != '0) && !one_hot;
    step_dir = (bin_s == (bin_prev + G_ONE));
    pos_step = step_dir ? (pos_q + P_ONE) : (pos_q - P_ONE);
    consume  = out_valid && out_ready;
    can_load = !out_valid || out_ready;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // FSM next state. Leaving FAULT goes through INIT so g_prev is resynced.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (en)        state_d = S_TRACK;
      S_TRACK: if (step_bad)  state_d = S_FAULT;
      S_FAULT: if (clear_err) state_d = S_INIT;
      default:                state_d = S_INIT;
    endcase
  end

  // Datapath: reference Gray value, position, sticky flags and output entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_prev    <= '0;
      pos_q     <= '0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_dir   <= 1'b0;
      out_pos   <= '0;
    end else begin
      if (state_q == S_INIT && en) g_prev <= g_s;
      if (step_ok) begin
        g_prev <= g_s;
        pos_q  <= pos_step;
      end
      // A new error takes precedence over a clear arriving on the same edge.
      if (step_bad)       err <= 1'b1;
      else if (clear_err) err <= 1'b0;
      if (step_ok && !can_load) overflow <= 1'b1;
      else if (clear_err)       overflow <= 1'b0;
      if (step_ok && can_load) begin
        out_valid <= 1'b1;
        out_bin   <= bin_s;
        out_dir   <= step_dir;
        out_pos   <= pos_step;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef GRAY2BIN_ERRCNT_EN
  // Saturating count of illegal transitions; clear_err does not reset it.
  always_ff @(posedge clk) begin
    if (rst)                            err_cnt <= 8'd0;
    else if (step_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

  assign pos   = pos_q;
  assign state = state_q;

endmodule

// File: tb/tb_gray2bin_tracker.sv
// Directed bench for gray2bin_tracker (WIDTH=4, POS_WIDTH=8, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, so every check sees settled values.
module tb_gray2bin_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'b0000;
  logic       en = 1'b0;
  logic       clear_err = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_bin;
  logic       out_dir;
  logic [7:0] out_pos;
  logic [7:0] pos;
  logic       err;
  logic       overflow;
  logic [1:0] state;
`ifdef GRAY2BIN_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
    logic       dir;
    logic [7:0] pos;
  } step_vec_t;

  step_vec_t vecs[8];
  logic [3:0] jumps[3];

  gray2bin_tracker #(.WIDTH(4), .POS_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .en(en), .clear_err(clear_err),
    .out_ready(out_ready), .out_valid(out_valid), .out_bin(out_bin),
    .out_dir(out_dir), .out_pos(out_pos), .pos(pos), .err(err),
    .overflow(overflow),
`ifdef GRAY2BIN_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .state(state)
  );

  // Clock and settle helper.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Apply a Gray value and wait for it to be compared (sync depth + 1 edges).
  task automatic step_wait(input logic [3:0] g);
    gray_in = g;
    tick(); tick(); tick();
  endtask

  // Pulse clear_err for one edge.
  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    // Up 0->3, back down to 0, then wrap below 0 and back above it.
    vecs[0] = '{4'b0001, 4'd1,  1'b1, 8'h01};
    vecs[1] = '{4'b0011, 4'd2,  1'b1, 8'h02};
    vecs[2] = '{4'b0010, 4'd3,  1'b1, 8'h03};
    vecs[3] = '{4'b0011, 4'd2,  1'b0, 8'h02};
    vecs[4] = '{4'b0001, 4'd1,  1'b0, 8'h01};
    vecs[5] = '{4'b0000, 4'd0,  1'b0, 8'h00};
    vecs[6] = '{4'b1000, 4'd15, 1'b0, 8'hFF};
    vecs[7] = '{4'b0000, 4'd0,  1'b1, 8'h00};
    jumps[0] = 4'b0000;
    jumps[1] = 4'b0011;
    jumps[2] = 4'b0000;

    // Reset state.
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_out_pos", 32'(out_pos), 32'd0);

    // INIT -> TRACK on the first enabled edge, with no event.
    en = 1'b1;
    tick();
    check("init_track", 32'(state), 32'd1);
    check("init_valid", 32'(out_valid), 32'd0);
    tick();
    check("init_pos", 32'(pos), 32'd0);

    // Table of legal steps with out_ready=1. The event appears 2 edges after
    // the input is sampled, not 1.
    for (int i = 0; i < 8; i++) begin
      gray_in = vecs[i].gray;
      tick(); tick();
      check($sformatf("lat_valid%0d", i), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bin%0d", i), 32'(out_bin), 32'(vecs[i].bin));
      check($sformatf("dir%0d", i), 32'(out_dir), 32'(vecs[i].dir));
      check($sformatf("out_pos%0d", i), 32'(out_pos), 32'(vecs[i].pos));
      check($sformatf("pos%0d", i), 32'(pos), 32'(vecs[i].pos));
    end

    // Illegal jump 0001 -> 0111 goes to FAULT. Later inputs are then ignored.
    step_wait(4'b0001);
    check("pre_err_pos", 32'(pos), 32'd1);
    step_wait(4'b0111);
    check("jump_err", 32'(err), 32'd1);
    check("jump_state", 32'(state), 32'd2);
    check("jump_pos", 32'(pos), 32'd1);
    check("jump_valid", 32'(out_valid), 32'd0);
    step_wait(4'b0101);
    step_wait(4'b0111);
    check("fault_ignore_state", 32'(state), 32'd2);
    check("fault_ignore_pos", 32'(pos), 32'd1);
    check("fault_ignore_valid", 32'(out_valid), 32'd0);
    pulse_clear();
    check("clr_err", 32'(err), 32'd0);
    check("clr_state_init", 32'(state), 32'd0);
    tick();
    check("resync_track", 32'(state), 32'd1);
    check("resync_valid", 32'(out_valid), 32'd0);
    check("resync_err", 32'(err), 32'd0);
    // The reference is now 0111 (bin 5), so 0110 (bin 4) is a down step.
    step_wait(4'b0110);
    check("resync_step_bin", 32'(out_bin), 32'd4);
    check("resync_step_dir", 32'(out_dir), 32'd0);
    check("resync_step_pos", 32'(pos), 32'd0);

    // Error and clear_err on the same edge: the error takes precedence.
    gray_in = 4'b0000;
    tick(); tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("err_wins_err", 32'(err), 32'd1);
    check("err_wins_state", 32'(state), 32'd2);
    pulse_clear();
    tick();
    check("recover_state", 32'(state), 32'd1);

    // Full entry: the first event is held, and the second is dropped while
    // pos keeps counting.
    out_ready = 1'b0;
    step_wait(4'b0001);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_out_pos", 32'(out_pos), 32'd1);
    step_wait(4'b0011);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_out_pos", 32'(out_pos), 32'd1);
    check("drop_out_bin", 32'(out_bin), 32'd1);
    check("drop_pos", 32'(pos), 32'd2);
    out_ready = 1'b1;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_clear();
    check("ovf_clr", 32'(overflow), 32'd0);
    check("clr_keeps_track", 32'(state), 32'd1);

    // Three more illegal jumps, each followed by clear_err. Two errors have
    // already been seen at this point, so the running total is 5.
    for (int i = 0; i < 3; i++) begin
      step_wait(jumps[i]);
      check($sformatf("multi_err%0d", i), 32'(err), 32'd1);
      check($sformatf("multi_state%0d", i), 32'(state), 32'd2);
      pulse_clear();
      tick();
    end
`ifdef GRAY2BIN_ERRCNT_EN
    check("err_cnt", 32'(err_cnt), 32'd5);
    pulse_clear();
    check("err_cnt_kept", 32'(err_cnt), 32'd5);
`endif

    // A reset mid-operation discards the pending entry and zeroes pos.
    out_ready = 1'b0;
    step_wait(4'b0001);
    check("pend_valid", 32'(out_valid), 32'd1);
    check("pend_pos", 32'(pos), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_pos", 32'(pos), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
`ifdef GRAY2BIN_ERRCNT_EN
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // While en=0, g_prev holds. When en returns, the value is compared with the
    // old g_prev.
    out_ready = 1'b1;
    en = 1'b0;
    tick(); tick(); tick();
    en = 1'b1;
    tick();
    check("en_init_track", 32'(state), 32'd1);
    en = 1'b0;
    step_wait(4'b0111);
    check("en_off_err", 32'(err), 32'd0);
    check("en_off_state", 32'(state), 32'd1);
    en = 1'b1;
    tick();
    check("en_back_err", 32'(err), 32'd1);
    check("en_back_state", 32'(state), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
